// File: rtl/dmem_access_ctrl_if.sv
// Bundles the command/response handshake with the data-memory pin bus.
// slave: controller view; master: core + memory view.
interface dmem_access_ctrl_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
);
  logic              req_valid;
  logic              req_ready;
  logic [1:0]        req_op;
  logic [ADDR_W-1:0] req_addr;
  logic [ADDR_W-1:0] req_dst;
  logic [ADDR_W-1:0] req_len;
  logic [DATA_W-1:0] req_data;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_data;
  logic              mem_E;
  logic              mem_WE;
  logic [ADDR_W-1:0] mem_Addr;
  logic [DATA_W-1:0] mem_DataIn;
  logic [DATA_W-1:0] mem_DataOut;

  modport slave (
    input  req_valid, req_op, req_addr, req_dst, req_len, req_data, rsp_ready, mem_DataOut,
    output req_ready, rsp_valid, rsp_data, mem_E, mem_WE, mem_Addr, mem_DataIn
  );

  modport master (
    output req_valid, req_op, req_addr, req_dst, req_len, req_data, rsp_ready, mem_DataOut,
    input  req_ready, rsp_valid, rsp_data, mem_E, mem_WE, mem_Addr, mem_DataIn
  );
endinterface

// File: rtl/dmem_access_ctrl.sv
// Data-memory access controller: single LOAD/STORE plus COPY/FILL block ops
// sequenced as a tiny DMA engine against a combinational-read, sync-write memory.
module dmem_access_ctrl #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  dmem_access_ctrl_if.slave   bus
);
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_STORE = 3'd2;
  localparam logic [2:0] S_CP_RD = 3'd3;
  localparam logic [2:0] S_CP_WR = 3'd4;
  localparam logic [2:0] S_FILL  = 3'd5;
  localparam logic [2:0] S_RSP   = 3'd6;

  localparam logic [1:0] OP_LOAD  = 2'b00;
  localparam logic [1:0] OP_STORE = 2'b01;
  localparam logic [1:0] OP_COPY  = 2'b10;
  localparam logic [1:0] OP_FILL  = 2'b11;

  localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);

  logic [2:0]        state;
  logic [ADDR_W-1:0] src, dst, cnt, mem_addr;
  // data_buf drives mem_DataIn directly: it is the STORE/FILL datum and the COPY byte buffer
  logic [DATA_W-1:0] data_buf, rsp_data;
  logic              accept;

  assign bus.req_ready  = (state == S_IDLE) & ~rst;
  assign accept         = bus.req_valid & bus.req_ready;
  assign bus.rsp_valid  = (state == S_RSP);
  assign bus.rsp_data   = rsp_data;
  assign bus.mem_Addr   = mem_addr;
  assign bus.mem_DataIn = data_buf;

  // Memory strobes decode straight from state so an async reset kills them at once
  always_comb begin
    bus.mem_E  = 1'b0;
    bus.mem_WE = 1'b0;
    case (state)
      S_LOAD, S_CP_RD:          bus.mem_E = 1'b1;
      S_STORE, S_CP_WR, S_FILL: begin
        bus.mem_E  = 1'b1;
        bus.mem_WE = 1'b1;
      end
      default: ;
    endcase
  end

  // Command sequencer: latches the request on accept, then walks addresses per op
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      src      <= '0;
      dst      <= '0;
      cnt      <= '0;
      mem_addr <= '0;
      data_buf <= '0;
      rsp_data <= '0;
    end else begin
      case (state)
        S_IDLE: if (accept) begin
          mem_addr <= bus.req_addr;
          src      <= bus.req_addr;
          dst      <= bus.req_dst;
          cnt      <= bus.req_len;
          rsp_data <= '0;
          case (bus.req_op)
            OP_LOAD:  state <= S_LOAD;
            OP_STORE: begin
              data_buf <= bus.req_data;
              state    <= S_STORE;
            end
            OP_COPY:  state <= S_CP_RD;
            OP_FILL:  begin
              data_buf <= bus.req_data;
              state    <= S_FILL;
            end
            default:  state <= S_IDLE;
          endcase
        end
        S_LOAD: begin
          rsp_data <= bus.mem_DataOut;
          state    <= S_RSP;
        end
        S_STORE: state <= S_RSP;
        S_FILL: begin
          cnt      <= cnt - ONE;
          mem_addr <= mem_addr + ONE;
          if (cnt == '0) state <= S_RSP;
        end
        S_CP_RD: begin
          data_buf <= bus.mem_DataOut;
          mem_addr <= dst;
          state    <= S_CP_WR;
        end
        S_CP_WR: begin
          // Ascending order: an overlapping dst>src range re-reads freshly written bytes
          src <= src + ONE;
          dst <= dst + ONE;
          cnt <= cnt - ONE;
          if (cnt == '0) begin
            state <= S_RSP;
          end else begin
            mem_addr <= src + ONE;
            state    <= S_CP_RD;
          end
        end
        S_RSP: if (bus.rsp_ready) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Bench for dmem_access_ctrl: table of commands with hand-computed results,
// plus hand sequences for reset, response back-pressure and reset mid-FILL.
module tb_dmem_access_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  dmem_access_ctrl_if #(.ADDR_W(4), .DATA_W(8)) bus ();
  dmem_access_ctrl #(.ADDR_W(4), .DATA_W(8)) dut (.clk(clk), .rst(rst), .bus(bus));

  // Memory model: combinational read, write on posedge when E&WE
  logic [7:0] mem [16] = '{default: 8'h00};
  int wr_cnt = 0;
  int rd_cnt = 0;
  assign bus.mem_DataOut = mem[bus.mem_Addr];
  always @(posedge clk) begin
    if (bus.mem_E === 1'b1) begin
      if (bus.mem_WE === 1'b1) begin
        mem[bus.mem_Addr] <= bus.mem_DataIn;
        wr_cnt++;
      end else begin
        rd_cnt++;
      end
    end
  end

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [1:0] op;
    logic [3:0] addr;
    logic [3:0] dst;
    logic [3:0] len;
    logic [7:0] data;
    logic [7:0] exp_rdata;
    int         exp_lat;
    int         exp_wr;
    int         exp_rd;
  } vec_t;
  vec_t vecs[$];

  function automatic void add(input logic [1:0] op, input logic [3:0] addr, input logic [3:0] dst,
                              input logic [3:0] len, input logic [7:0] data, input logic [7:0] exp_rdata,
                              input int exp_lat, input int exp_wr, input int exp_rd);
    vec_t v;
    v.op = op; v.addr = addr; v.dst = dst; v.len = len; v.data = data;
    v.exp_rdata = exp_rdata; v.exp_lat = exp_lat; v.exp_wr = exp_wr; v.exp_rd = exp_rd;
    vecs.push_back(v);
  endfunction

  // Present a command, wait for accept, count posedges from the accept edge
  // (inclusive) until rsp_valid is seen, then complete the response handshake.
  task automatic do_cmd(input vec_t v, output logic [7:0] rdata, output int lat);
    int n;
    @(negedge clk);
    bus.req_op = v.op; bus.req_addr = v.addr; bus.req_dst = v.dst;
    bus.req_len = v.len; bus.req_data = v.data; bus.req_valid = 1'b1;
    n = 0;
    while (bus.req_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      check("accept_timeout", 32'(n), 32'd0);
    end
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.req_op = 2'bxx; bus.req_addr = 'x; bus.req_data = 'x;
    while (bus.rsp_valid !== 1'b1 && lat < 100) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    rdata = bus.rsp_data;
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.rsp_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] rdata;
    int lat, wr0, rd0;

    bus.req_valid = 1'b0; bus.req_op = 2'b00; bus.req_addr = '0; bus.req_dst = '0;
    bus.req_len = '0; bus.req_data = '0; bus.rsp_ready = 1'b0;

    // Command table (memory starts all-zero)
    add(2'b01, 4'd3,  4'd0, 4'd0, 8'hA5, 8'h00, 2, 1, 0);   // STORE A5 @3
    add(2'b00, 4'd3,  4'd0, 4'd0, 8'h00, 8'hA5, 2, 0, 1);   // LOAD @3
    add(2'b11, 4'd14, 4'd0, 4'd3, 8'h5C, 8'h00, 5, 4, 0);   // FILL 14,15,0,1
    add(2'b00, 4'd15, 4'd0, 4'd0, 8'h00, 8'h5C, 2, 0, 1);
    add(2'b00, 4'd1,  4'd0, 4'd0, 8'h00, 8'h5C, 2, 0, 1);
    add(2'b00, 4'd13, 4'd0, 4'd0, 8'h00, 8'h00, 2, 0, 1);   // untouched below
    add(2'b00, 4'd2,  4'd0, 4'd0, 8'h00, 8'h00, 2, 0, 1);   // untouched above
    for (int i = 0; i < 8; i++) add(2'b01, 4'(i), 4'd0, 4'd0, 8'h10 + 8'(i), 8'h00, 2, 1, 0);
    add(2'b10, 4'd0,  4'd8, 4'd7, 8'h00, 8'h00, 17, 8, 8);  // COPY 0..7 -> 8..15
    add(2'b00, 4'd8,  4'd0, 4'd0, 8'h00, 8'h10, 2, 0, 1);
    add(2'b00, 4'd15, 4'd0, 4'd0, 8'h00, 8'h17, 2, 0, 1);
    add(2'b10, 4'd0,  4'd1, 4'd2, 8'h00, 8'h00, 7, 3, 3);   // overlap: mem1..3 <- 10
    add(2'b00, 4'd3,  4'd0, 4'd0, 8'h00, 8'h10, 2, 0, 1);
    add(2'b00, 4'd4,  4'd0, 4'd0, 8'h00, 8'h14, 2, 0, 1);
    add(2'b10, 4'd6,  4'd6, 4'd0, 8'h00, 8'h00, 3, 1, 1);   // src==dst
    add(2'b00, 4'd6,  4'd0, 4'd0, 8'h00, 8'h16, 2, 0, 1);
    add(2'b11, 4'd5,  4'd0, 4'd0, 8'h77, 8'h00, 2, 1, 0);   // FILL single byte
    add(2'b00, 4'd5,  4'd0, 4'd0, 8'h00, 8'h77, 2, 0, 1);

    // Async reset asserted mid-cycle
    #13 rst = 1'b1;
    #1;
    check("rst_req_ready", 32'(bus.req_ready), 32'd0);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_rsp_data", 32'(bus.rsp_data), 32'd0);
    check("rst_mem_E", 32'(bus.mem_E), 32'd0);
    check("rst_mem_WE", 32'(bus.mem_WE), 32'd0);
    check("rst_mem_Addr", 32'(bus.mem_Addr), 32'd0);
    check("rst_mem_DataIn", 32'(bus.mem_DataIn), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("post_rst_req_ready", 32'(bus.req_ready), 32'd1);

    foreach (vecs[i]) begin
      wr0 = wr_cnt; rd0 = rd_cnt;
      do_cmd(vecs[i], rdata, lat);
      check($sformatf("vec%0d_rsp_data", i), 32'(rdata), 32'(vecs[i].exp_rdata));
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].exp_lat));
      check($sformatf("vec%0d_writes", i), 32'(wr_cnt - wr0), 32'(vecs[i].exp_wr));
      check($sformatf("vec%0d_reads", i), 32'(rd_cnt - rd0), 32'(vecs[i].exp_rd));
    end

    // Response back-pressure: LOAD @8 held 5 cycles while a STORE waits
    wr0 = wr_cnt;
    @(negedge clk);
    bus.req_op = 2'b00; bus.req_addr = 4'd8; bus.req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.req_op = 2'b01; bus.req_addr = 4'd9; bus.req_data = 8'hFF;
    @(posedge clk);
    @(negedge clk);
    for (int c = 0; c < 5; c++) begin
      check($sformatf("bp%0d_rsp_valid", c), 32'(bus.rsp_valid), 32'd1);
      check($sformatf("bp%0d_rsp_data", c), 32'(bus.rsp_data), 32'h10);
      check($sformatf("bp%0d_req_ready", c), 32'(bus.req_ready), 32'd0);
      @(posedge clk);
      @(negedge clk);
    end
    bus.rsp_ready = 1'b1;
    bus.req_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    check("bp_done_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("bp_done_req_ready", 32'(bus.req_ready), 32'd1);
    check("bp_no_write", 32'(wr_cnt - wr0), 32'd0);
    check("bp_mem9", 32'(mem[9]), 32'h11);

    // Reset two write cycles into a FILL len=7 @0
    wr0 = wr_cnt;
    @(negedge clk);
    bus.req_op = 2'b11; bus.req_addr = 4'd0; bus.req_len = 4'd7; bus.req_data = 8'hEE;
    bus.req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    check("fill_mem_E_active", 32'(bus.mem_E), 32'd1);
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("fill_rst_mem_E", 32'(bus.mem_E), 32'd0);
    check("fill_rst_mem_WE", 32'(bus.mem_WE), 32'd0);
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("fill_rst_writes", 32'(wr_cnt - wr0), 32'd2);
    check("fill_rst_mem0", 32'(mem[0]), 32'hEE);
    check("fill_rst_mem1", 32'(mem[1]), 32'hEE);
    check("fill_rst_mem2", 32'(mem[2]), 32'h10);
    check("fill_rst_req_ready", 32'(bus.req_ready), 32'd1);
    check("fill_rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
